// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and constants for the RV32M multiply/divide unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } funct3_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [31:0] DIV_ZERO_Q = '1;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the EX stage and the multiply/divide unit
// master (pipeline): drives start, flush, Funct3, SrcA, SrcB; sees busy, done, Result
// slave (unit): the mirror image
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) ();
  logic start;
  logic flush;
  funct3_t Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic busy;
  logic done;
  logic [XLEN-1:0] Result;
  modport master (output start, flush, Funct3, SrcA, SrcB, input busy, done, Result);
  modport slave (input start, flush, Funct3, SrcA, SrcB, output busy, done, Result);
endinterface

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step: one combinational shift-add (multiply) or restoring shift-subtract (divide) iteration
// is_div selects the mode; operand is the multiplicand or divisor magnitude
// multiply acc = {high partial product, remaining multiplier bits}; divide acc = {partial remainder, dividend/quotient bits}
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   operand,
  input  logic [2*XLEN-1:0] acc_in,
  output logic [2*XLEN-1:0] acc_out
);
  logic [XLEN:0] sum, r;
  logic ge;
  always_comb begin
    sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
    r = acc_in[2*XLEN-1:XLEN-1];
    ge = r >= {1'b0, operand};
    acc_out = is_div ? {ge ? XLEN'(r - {1'b0, operand}) : r[XLEN-1:0], acc_in[XLEN-2:0], ge}
                     : {sum, acc_in[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit with its own IDLE/BUSY/DONE sequencer
// clk, reset: clock and synchronous active-high reset
// bus (muldiv_if.slave): start, flush, Funct3, SrcA, SrcB in; busy, done (one-cycle), Result out
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  state_t state, state_n;
  funct3_t op;
  logic sign;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] opnd, result, a_mag, b_mag, special_res, fin, quot, rem;
  logic [2*XLEN-1:0] acc, acc_step, prod;
  logic a_neg, b_neg, sign_in, is_div, div_zero, ovf, special, accept, last;
  muldiv_iter_step #(.XLEN(XLEN)) u_step (
    .is_div (op[2]),
    .operand(opnd),
    .acc_in (acc),
    .acc_out(acc_step)
  );
  // a_neg/b_neg are only set for operands the op treats as signed
  always_comb begin
    is_div = bus.Funct3[2];
    a_neg = bus.SrcA[XLEN-1] && bus.Funct3 inside {MUL, MULH, MULHSU, DIV, REM};
    b_neg = bus.SrcB[XLEN-1] && bus.Funct3 inside {MUL, MULH, DIV, REM};
    a_mag = a_neg ? -bus.SrcA : bus.SrcA;
    b_mag = b_neg ? -bus.SrcB : bus.SrcB;
    sign_in = a_neg ^ (b_neg && bus.Funct3 != REM);
    div_zero = is_div && bus.SrcB == '0;
    ovf = bus.Funct3 inside {DIV, REM} && bus.SrcA == {1'b1, {(XLEN-1){1'b0}}} && bus.SrcB == '1;
    special = div_zero || ovf;
    special_res = div_zero ? (bus.Funct3[1] ? bus.SrcA : '1) : (bus.Funct3[1] ? '0 : bus.SrcA);
    accept = state == S_IDLE && bus.start && !bus.flush;
    last = cnt == CW'(XLEN - 1);
    state_n = state == S_IDLE ? (accept ? (special ? S_DONE : S_BUSY) : S_IDLE)
            : state == S_BUSY ? (bus.flush ? S_IDLE : last ? S_DONE : S_BUSY)
            : S_IDLE;
    prod = sign ? -acc_step : acc_step;
    quot = acc_step[XLEN-1:0];
    rem = acc_step[2*XLEN-1:XLEN];
    fin = op == MUL ? prod[XLEN-1:0]
        : !op[2]    ? prod[2*XLEN-1:XLEN]
        : op[1]     ? (sign ? -rem : rem)
        :             (sign ? -quot : quot);
  end
  // Result is taken from the step output so the final iteration lands in the same edge as DONE entry
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      op <= MUL;
      sign <= 1'b0;
      cnt <= '0;
      opnd <= '0;
      acc <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op <= bus.Funct3;
        sign <= sign_in;
        cnt <= '0;
        opnd <= is_div ? b_mag : a_mag;
        acc <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
        if (special) result <= special_res;
      end else if (state == S_BUSY) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
        if (last && !bus.flush) result <= fin;
      end
    end
  assign bus.busy = state == S_BUSY;
  assign bus.done = state == S_DONE;
  assign bus.Result = result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer against an arithmetic reference model
module tb_muldiv_sequencer;
  import muldiv_pkg::*;
  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_exp = '0;
  exp_t sb[$];
  muldiv_if #(.XLEN(32)) bus ();
  muldiv_sequencer #(.XLEN(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] model(funct3_t f, logic [31:0] a, logic [31:0] b);
    longint sa, sbv, ua, ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      MUL:    begin p = sa * sbv; return p[31:0]; end
      MULH:   begin p = sa * sbv; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sbv;
        return p[31:0];
      end
      DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sbv;
        return p[31:0];
      end
      REMU: begin
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  always @(negedge clk)
    if (bus.done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: done high at cycle %0d with no operation outstanding", cyc);
      end else begin
        e = sb.pop_front();
        check("result", 64'(bus.Result), 64'(e.res));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  task automatic start_op(funct3_t f, logic [31:0] a, logic [31:0] b, bit track);
    bit sp;
    sp = f[2] && (b == 0 || ((f == DIV || f == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    bus.start = 1'b1;
    bus.Funct3 = f;
    bus.SrcA = a;
    bus.SrcB = b;
    if (track) begin
      last_exp = model(f, a, b);
      sb.push_back('{last_exp, cyc + (sp ? 1 : 33)});
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.Funct3 = funct3_t'($urandom_range(0, 7));
    bus.SrcA = $urandom;
    bus.SrcB = $urandom;
    check("busy_after_start", 64'(bus.busy), 64'(!sp));
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: unit still active after %0d cycles", n);
    end
  endtask
  task automatic run(funct3_t f, logic [31:0] a, logic [31:0] b);
    start_op(f, a, b, 1'b1);
    wait_idle();
  endtask
  initial begin
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.Funct3 = MUL;
    bus.SrcA = '0;
    bus.SrcB = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_result", 64'(bus.Result), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    run(MUL, 32'd7, 32'hFFFF_FFFD);
    run(MULH, 32'd7, 32'hFFFF_FFFD);
    run(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(MULHSU, 32'hFFFF_FFFF, 32'd2);
    run(DIV, -32'sd20, 32'd3);
    run(REM, -32'sd20, 32'd3);
    run(DIVU, 32'd20, 32'd3);
    run(DIVU, 32'd5, 32'd0);
    run(REMU, 32'd5, 32'd0);
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run(REM, 32'h8000_0000, 32'hFFFF_FFFF);
    start_op(DIV, 32'd1000, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'(0));
    check("flush_done", 64'(bus.done), 64'(0));
    check("flush_result", 64'(bus.Result), 64'(last_exp));
    repeat (40) @(negedge clk);
    start_op(MUL, 32'd12345, 32'd678, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.Funct3 = DIVU;
    bus.SrcA = 32'd99;
    bus.SrcB = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    start_op(MUL, $urandom, $urandom, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_exp = '0;
    check("midop_reset_busy", 64'(bus.busy), 64'(0));
    check("midop_reset_done", 64'(bus.done), 64'(0));
    check("midop_reset_result", 64'(bus.Result), 64'(0));
    run(MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (200) run(funct3_t'($urandom_range(0, 7)), rnd_op(), rnd_op());
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
